instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the fdt16 CPU. Maintains the program counter, issues word reads to instruction memory over a req/ack handshake, and presents 16-bit instruction words, with their PC, to the instruction decoder. A two-entry buffer (output register plus skid register) absorbs decode back-pressure without losing data. A branch redirect flushes the buffer and any in-flight fetch.

## Interface

- `ADDR_W`, default 16: PC and instruction-memory word-address width.
- `RESET_PC`, default 0: PC value loaded on reset.

One clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  word address of the current request.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; valid only while `imem_req`=1.
- `imem_rdata`  in  16  instruction word; valid with `imem_ack`.
- `stall`  in  1  decode cannot accept the instruction this cycle.
- `branch_taken`  in  1  single-cycle redirect pulse.
- `branch_target`  in  ADDR_W  new PC; valid with `branch_taken`.
- `instr`  out  16  instruction word to the decoder.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a live instruction.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.

## Operation

- **State**
  - `pc`: next address to request.
  - `running` flag.
  - `discard` flag.
  - OUT register: `instr`, `instr_pc`, `instr_valid`.
  - SKID register: `skid_instr`, `skid_pc`, `skid_valid`.
- **Reset** (any cycle with `rst`=1, overrides all other inputs):
  - `pc`=`RESET_PC`.
  - `running`=0, `discard`=0.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - SKID cleared.
  - `imem_req`=0; `imem_addr`=`RESET_PC` (equals `pc`).
- **Request**
  - `imem_req` = `running` && !`skid_valid`, combinational from registers.
  - `imem_addr` = `pc`.
  - `pc` does not change while `imem_req`=1 and `imem_ack`=0, so the address is stable until acked.
- **Consume**: OUT is consumed in a cycle where `instr_valid`=1 and `stall`=0.
- **Accept**: a cycle where `imem_ack`=1, `imem_req`=1, `discard`=0 and `branch_taken`=0.
  - `pc` increments by 1, wrapping from all-ones to 0.
  - The data goes to OUT if OUT is empty or being consumed and SKID is empty; otherwise it goes to SKID.
- **OUT refill on consume**, in priority order:
  - SKID contents, if SKID is valid; SKID is then cleared, or refilled by a same-cycle accept.
  - Otherwise the accepted data, if any.
  - Otherwise `instr_valid` goes to 0.
- **Ordering**: instructions always leave in fetch order.
- **Branch** (`branch_taken`=1, priority over accept and stall):
  - `pc` = `branch_target`.
  - OUT and SKID are invalidated next cycle.
  - An instruction consumed in the same cycle counts as delivered.
  - If `imem_req`=1 and `imem_ack`=0 in that cycle, set `discard`=1.
  - If `imem_ack`=1 in that cycle, the returned data is dropped.
- **Discard**
  - While `discard`=1, `imem_req` stays high at the old address; no new address is issued.
  - The next `imem_ack` is dropped and clears `discard`.
  - A second branch while `discard`=1 only updates `pc`.
  - Once `discard` clears, requests resume at the most recent target.

## Timing

- **Reset release**: after the first edge with `rst`=0, `running`=1; `imem_req`=1 with `imem_addr`=`RESET_PC` in the following cycle.
- **Fetch latency**: `imem_ack` in cycle N gives `instr_valid`=1 with that data in cycle N+1, unless the data lands in SKID.
- **Throughput**: with `imem_ack` held high and `stall` low, one instruction per cycle and back-to-back addresses.
- **Back-pressure**: OUT full and stalled plus one accept fills SKID; `imem_req` drops the next cycle. It rises again the cycle after SKID drains.
- **Branch**: `branch_taken` in cycle N gives `instr_valid`=0 in N+1.
  - If no request is outstanding, `imem_addr`=`branch_target` in N+1.
  - Otherwise the redirect waits for the discarded ack.
- **Mid-operation reset**: all state is cleared at the next edge regardless of pending ack, stall or branch.

## Test plan

- **Reset**: hold `rst`=1 for 3 cycles with `imem_ack`=1 -> `imem_req`=0, `instr_valid`=0, `instr`=0 throughout. Release -> `imem_req`=1, `imem_addr`=0x0000 one cycle later.
- **Streaming**: ack every cycle with 0x0000, 0xFFFF, 0x8001, `stall`=0 -> `instr_valid`=1 for 3 consecutive cycles with `instr_pc` 0, 1, 2 and matching words.
- **Back-pressure**: raise `stall` for 4 cycles while acking each request.
  - Exactly one extra word enters SKID, then `imem_req`=0.
  - After `stall` drops, words appear in order with no loss or duplication.
- **Branch with in-flight fetch**: request at 0x0005 outstanding, ack delayed 3 cycles; pulse `branch_taken` with `branch_target`=0x0040.
  - `instr_valid`=0 next cycle.
  - The delayed data is never presented.
  - The next `imem_addr` is 0x0040; the first delivered `instr_pc` is 0x0040.
- **Wrap**: `RESET_PC`=0xFFFE with continuous acks -> addresses 0xFFFE, 0xFFFF, 0x0000.
- **Mid-operation reset**: with OUT and SKID full and `stall`=1, assert `rst` for 1 cycle -> next cycle `instr_valid`=0, `skid_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage of the fdt16 CPU. Holds the program
//             counter, issues word reads to instruction memory over a req/ack
//             handshake and hands 16-bit instruction words, tagged with their
//             PC, to the decoder. An output register plus a skid register
//             absorb decode back-pressure without dropping words. A branch
//             redirect flushes both registers and any in-flight fetch.
//
//  Ports    :
//    clk            in   1       rising-edge clock
//    rst            in   1       synchronous active-high reset
//    imem_req       out  1       fetch request to instruction memory
//    imem_addr      out  ADDR_W  word address of the current request
//    imem_ack       in   1       imem_rdata valid this cycle (only with req)
//    imem_rdata     in   16      returned instruction word
//    stall          in   1       decoder cannot take the instruction
//    branch_taken   in   1       single-cycle redirect pulse
//    branch_target  in   ADDR_W  redirect address, valid with branch_taken
//    instr          out  16      instruction word to the decoder
//    instr_valid    out  1       instr / instr_pc hold a live instruction
//    instr_pc       out  ADDR_W  address instr was fetched from
//
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned       c_INSTR_W = 16;
    localparam logic [ADDR_W-1:0] c_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PC_ZERO = '0;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]    pc_q,          pc_d;
    logic                 running_q,     running_d;
    logic                 discard_q,     discard_d;
    // Address of the request whose ack is being thrown away. pc_q already
    // points at the branch target while that old request is still pending,
    // so the old address has to be held separately to keep imem_addr stable.
    logic [ADDR_W-1:0]    hold_addr_q,   hold_addr_d;

    logic [c_INSTR_W-1:0] out_instr_q,   out_instr_d;
    logic [ADDR_W-1:0]    out_pc_q,      out_pc_d;
    logic                 out_valid_q,   out_valid_d;

    logic [c_INSTR_W-1:0] skid_instr_q,  skid_instr_d;
    logic [ADDR_W-1:0]    skid_pc_q,     skid_pc_d;
    logic                 skid_valid_q,  skid_valid_d;

    // ------------------------------------------------------------------
    // Combinational handshake terms
    // ------------------------------------------------------------------
    logic w_req;
    logic w_accept;
    logic w_consume;

    // Requests stop as soon as the skid register holds a word: at that
    // point both buffer entries are occupied and nothing could be stored.
    assign w_req     = running_q & ~skid_valid_q;

    assign w_accept  = imem_ack & w_req & ~discard_q & ~branch_taken;
    assign w_consume = out_valid_q & ~stall;

    assign imem_req    = w_req;
    assign imem_addr   = discard_q ? hold_addr_q : pc_q;

    assign instr       = out_instr_q;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_valid_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        running_d     = 1'b1;
        discard_d     = discard_q;
        hold_addr_d   = hold_addr_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_valid_d   = out_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;

        if (branch_taken) begin
            // Redirect wins over accept and stall. Anything the decoder
            // takes this cycle is already delivered; the rest is flushed.
            pc_d         = branch_target;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;

            if (w_req && !imem_ack) begin
                // A request is still open: its eventual ack must be thrown
                // away. If one is already being discarded, the held address
                // is the one still on the bus, so leave it alone.
                discard_d = 1'b1;
                if (!discard_q) begin
                    hold_addr_d = pc_q;
                end
            end else if (discard_q && imem_ack) begin
                discard_d = 1'b0;
            end
        end else begin
            if (discard_q && imem_ack && w_req) begin
                discard_d = 1'b0;
            end

            if (w_accept) begin
                pc_d = pc_q + c_PC_ONE;
            end

            if (w_consume) begin
                if (skid_valid_q) begin
                    // Oldest word lives in skid; it moves forward first.
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                    out_valid_d = 1'b1;
                    if (w_accept) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (w_accept) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (w_accept) begin
                if (!out_valid_q && !skid_valid_q) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                end else begin
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = pc_q;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            running_q    <= 1'b0;
            discard_q    <= 1'b0;
            hold_addr_q  <= RESET_PC;
            out_instr_q  <= '0;
            out_pc_q     <= c_PC_ZERO;
            out_valid_q  <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= c_PC_ZERO;
            skid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            running_q    <= running_d;
            discard_q    <= discard_d;
            hold_addr_q  <= hold_addr_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch. Accepted fetches
//             are pushed into a scoreboard queue and popped when the decoder
//             side consumes an instruction. A second instance built with
//             RESET_PC = 0xFFFE and a always-acking memory checks wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;

    logic        w_wrap_req;
    logic [15:0] w_wrap_addr;
    logic [15:0] w_wrap_instr;
    logic        w_wrap_valid;
    logic [15:0] w_wrap_pc;

    int   n_checks;
    int   n_errors;
    ent_t sb[$];
    logic [15:0] m_pc;
    logic        m_discard;
    logic [15:0] m_hold;

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc)
    );

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (w_wrap_req),
        .imem_addr     (w_wrap_addr),
        .imem_ack      (w_wrap_req),
        .imem_rdata    (w_wrap_addr),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (16'h0000),
        .instr         (w_wrap_instr),
        .instr_valid   (w_wrap_valid),
        .instr_pc      (w_wrap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score whatever the current inputs/outputs mean for
    // this cycle, then advance to just after the next rising edge.
    task automatic tick();
        ent_t e;
        if (rst) begin
            sb.delete();
            m_pc      = 16'h0000;
            m_discard = 1'b0;
        end else begin
            if (instr_valid === 1'b1 && !stall) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("instr", 32'(instr), 32'(e.data));
                    check("instr_pc", 32'(instr_pc), 32'(e.pc));
                end
            end
            if (imem_ack) begin
                check("req_on_ack", 32'(imem_req), 32'd1);
                if (m_discard) begin
                    check("discard_addr", 32'(imem_addr), 32'(m_hold));
                    m_discard = 1'b0;
                end else if (!branch_taken) begin
                    check("ack_addr", 32'(imem_addr), 32'(m_pc));
                    e.pc   = m_pc;
                    e.data = imem_rdata;
                    sb.push_back(e);
                    m_pc = m_pc + 16'h0001;
                end
            end
            if (branch_taken) begin
                sb.delete();
                m_pc = branch_target;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        m_pc          = 16'h0000;
        m_discard     = 1'b0;
        m_hold        = 16'h0000;
        rst           = 1'b1;
        imem_ack      = 1'b1;
        imem_rdata    = 16'h0000;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        // ---- reset held for 3 cycles with ack asserted ----
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", 32'(instr), 32'd0);
            check("rst_addr", 32'(imem_addr), 32'h0000);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        imem_ack = 1'b0;
        check("rel_req_first", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", 32'(imem_addr), 32'h0000);
        check("wrap_addr0", 32'(w_wrap_addr), 32'hFFFE);

        // ---- streaming ----
        imem_ack   = 1'b1;
        imem_rdata = 16'h0000;
        tick();
        check("wrap_addr1", 32'(w_wrap_addr), 32'hFFFF);
        check("wrap_pc1", 32'(w_wrap_pc), 32'hFFFE);
        imem_rdata = 16'hFFFF;
        tick();
        check("wrap_addr2", 32'(w_wrap_addr), 32'h0000);
        check("wrap_pc2", 32'(w_wrap_pc), 32'hFFFF);
        imem_rdata = 16'h8001;
        tick();
        check("wrap_pc3", 32'(w_wrap_pc), 32'h0000);
        check("wrap_instr3", 32'(w_wrap_instr), 32'h0000);
        imem_ack = 1'b0;
        check("stream_valid3", 32'(instr_valid), 32'd1);
        tick();
        check("stream_drained", 32'(instr_valid), 32'd0);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // ---- back-pressure ----
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hA003;
        tick();
        check("bp_req_out_full", 32'(imem_req), 32'd1);
        imem_rdata = 16'hA004;
        tick();
        imem_ack = 1'b0;
        check("bp_req_skid_full", 32'(imem_req), 32'd0);
        check("bp_skid_valid", 32'(dut.skid_valid_q), 32'd1);
        tick();
        check("bp_req_hold", 32'(imem_req), 32'd0);
        tick();
        stall = 1'b0;
        check("bp_req_draining", 32'(imem_req), 32'd0);
        tick();
        check("bp_req_resume", 32'(imem_req), 32'd1);
        check("bp_addr_resume", 32'(imem_addr), 32'h0005);

        // ---- branch with an in-flight fetch at 0x0005 ----
        stall = 1'b1;
        tick();
        check("br_req_open", 32'(imem_req), 32'd1);
        check("br_valid_before", 32'(instr_valid), 32'd1);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        m_discard     = 1'b1;
        m_hold        = 16'h0005;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("br_flush_valid", 32'(instr_valid), 32'd0);
        check("br_addr_held", 32'(imem_addr), 32'h0005);
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        check("br_req_target", 32'(imem_req), 32'd1);
        check("br_addr_target", 32'(imem_addr), 32'h0040);
        check("br_dropped", 32'(instr_valid), 32'd0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'hB040;
        tick();
        imem_ack = 1'b0;
        check("br_first_valid", 32'(instr_valid), 32'd1);
        tick();
        check("br_sb_empty", 32'(sb.size()), 32'd0);

        // ---- mid-operation reset with OUT and SKID full ----
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hC041;
        tick();
        imem_rdata = 16'hC042;
        tick();
        imem_ack = 1'b0;
        check("mr_out_full", 32'(instr_valid), 32'd1);
        check("mr_skid_full", 32'(dut.skid_valid_q), 32'd1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_skid", 32'(dut.skid_valid_q), 32'd0);
        check("mr_req", 32'(imem_req), 32'd0);
        check("mr_addr", 32'(imem_addr), 32'h0000);
        tick();
        check("mr_req_resume", 32'(imem_req), 32'd1);
        check("mr_addr_resume", 32'(imem_addr), 32'h0000);

        // ---- branch coinciding with an ack: data dropped, no discard ----
        imem_ack      = 1'b1;
        imem_rdata    = 16'h1234;
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        tick();
        branch_taken = 1'b0;
        check("ba_valid", 32'(instr_valid), 32'd0);
        check("ba_req", 32'(imem_req), 32'd1);
        check("ba_addr", 32'(imem_addr), 32'h0100);
        imem_rdata = 16'h5100;
        tick();
        imem_ack = 1'b0;
        tick();
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("end_valid", 32'(instr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
